// File: rtl/x_ramb_dp_param.sv
// True dual-port block RAM, one clock, per-port read-during-write mode, port A wins same-address writes.
// Latency: read data and COLL 1 cycle; 2 cycles when X_RAMB_DP_OUTREG_EN is defined (extra output register).
// Backpressure: none; each port is always ready, and a disabled port holds DO and ignores WE.
module x_ramb_dp_param #(
    parameter int DATA_WIDTH   = 2,
    parameter int ADDR_WIDTH   = 11,
    parameter int WRITE_MODE_A = 0,   // 0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE
    parameter int WRITE_MODE_B = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENA,
    input  logic                  ENB,
    input  logic                  WEA,
    input  logic                  WEB,
    input  logic [ADDR_WIDTH-1:0] ADDRA,
    input  logic [ADDR_WIDTH-1:0] ADDRB,
    input  logic [DATA_WIDTH-1:0] DIA,
    input  logic [DATA_WIDTH-1:0] DIB,
    output logic [DATA_WIDTH-1:0] DOA,
    output logic [DATA_WIDTH-1:0] DOB,
    output logic                  COLL
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Zero at time zero; only writes change it afterwards, reset leaves it alone.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    logic [DATA_WIDTH-1:0] r_doa;
    logic [DATA_WIDTH-1:0] r_dob;
    logic                  r_coll;

    logic w_wr_a;
    logic w_wr_b;
    logic w_coll;

    assign w_wr_a = ENA & WEA;
    assign w_wr_b = ENB & WEB;
    assign w_coll = w_wr_a & w_wr_b & (ADDRA == ADDRB);

    // Memory array update: port B is dropped on a same-address collision so DIA is stored.
    always_ff @(posedge CLK) begin
        if (w_wr_b && !w_coll) begin
            r_mem[ADDRB] <= DIB;
        end
        if (w_wr_a) begin
            r_mem[ADDRA] <= DIA;
        end
    end

    // Port A data out; reads of r_mem see pre-edge contents, giving cross-port read-first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_doa <= '0;
        end else if (ENA) begin
            if (!WEA) begin
                r_doa <= r_mem[ADDRA];
            end else if (WRITE_MODE_A == 0) begin
                r_doa <= DIA;
            end else if (WRITE_MODE_A == 1) begin
                r_doa <= r_mem[ADDRA];
            end
            // NO_CHANGE (and any other encoding): hold during own-port writes.
        end
    end

    // Port B data out, same structure as port A with its own mode.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dob <= '0;
        end else if (ENB) begin
            if (!WEB) begin
                r_dob <= r_mem[ADDRB];
            end else if (WRITE_MODE_B == 0) begin
                r_dob <= DIB;
            end else if (WRITE_MODE_B == 1) begin
                r_dob <= r_mem[ADDRB];
            end
        end
    end

    // Collision flag: one-cycle pulse per colliding edge, suppressed while in reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_coll <= 1'b0;
        end else begin
            r_coll <= w_coll;
        end
    end

`ifdef X_RAMB_DP_OUTREG_EN
    logic [DATA_WIDTH-1:0] r_doa_q;
    logic [DATA_WIDTH-1:0] r_dob_q;
    logic                  r_coll_q;
    logic                  r_ena_d;
    logic                  r_enb_d;

    // Enables travel with the data so the output stage only loads for active cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ena_d <= 1'b0;
            r_enb_d <= 1'b0;
        end else begin
            r_ena_d <= ENA;
            r_enb_d <= ENB;
        end
    end

    // Output pipeline stage for data and collision flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_doa_q  <= '0;
            r_dob_q  <= '0;
            r_coll_q <= 1'b0;
        end else begin
            if (r_ena_d) begin
                r_doa_q <= r_doa;
            end
            if (r_enb_d) begin
                r_dob_q <= r_dob;
            end
            r_coll_q <= r_coll;
        end
    end

    assign DOA  = r_doa_q;
    assign DOB  = r_dob_q;
    assign COLL = r_coll_q;
`else
    assign DOA  = r_doa;
    assign DOB  = r_dob;
    assign COLL = r_coll;
`endif

endmodule
